// File: rtl/abc_pkg.sv
// Shared types and default sizes for the abc packet bus receiver.
package abc_pkg;

  localparam int ABC_DATA_W        = 64;
  localparam int ABC_PAYLOAD_BEATS = 8;
  localparam int ABC_GAP_W         = 6;

  typedef logic [ABC_DATA_W-1:0] abc_beat_t;
  typedef abc_beat_t [ABC_PAYLOAD_BEATS-1:0] abc_payload_t;

  typedef struct packed {
    abc_beat_t              header;
    abc_payload_t           payload;
    abc_beat_t              trailer;
    logic [ABC_GAP_W-1:0]   gap;
  } abc_pkt_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    TRAILER = 2'd2
  } abc_rx_state_e;

endpackage

// File: rtl/abc_rx_gap_counter.sv
// Saturating idle-beat counter; the value latched at a header is the distance
// in beats from the previous trailer, so a back-to-back header reads 1.
module abc_rx_gap_counter
  import abc_pkg::*;
#(
  parameter int GAP_W = ABC_GAP_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic             latch_i,
  output logic [GAP_W-1:0] gap_o
);

  localparam logic [GAP_W-1:0] GAP_MAX = '1;

  logic [GAP_W-1:0] cnt_q, cnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != GAP_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
    gap_d = gap_q;
    if (latch_i) begin
      gap_d = (cnt_q == GAP_MAX) ? GAP_MAX : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      gap_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      gap_q <= gap_d;
    end
  end

  assign gap_o = gap_q;

endmodule

// File: rtl/abc_rx.sv
// abc bus receiver: deframes header + payload + trailer into a valid/ready packet register.
// Optional inter-packet gap measurement is enabled by defining ABC_RX_GAP_MEASURE_EN.
module abc_rx
  import abc_pkg::*;
#(
  parameter int DATA_W        = ABC_DATA_W,
  parameter int PAYLOAD_BEATS = ABC_PAYLOAD_BEATS,
  parameter int GAP_W         = ABC_GAP_W
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            sop,
  input  logic                            eop,
  input  logic [DATA_W-1:0]               data,
  output logic                            pkt_valid,
  input  logic                            pkt_ready,
  output logic [DATA_W-1:0]               pkt_header,
  output logic [PAYLOAD_BEATS*DATA_W-1:0] pkt_payload,
  output logic [DATA_W-1:0]               pkt_trailer,
  output logic [GAP_W-1:0]                pkt_gap,
  output logic                            frame_err,
  output logic                            ovf_err
);

  localparam int CNT_W = (PAYLOAD_BEATS > 1) ? $clog2(PAYLOAD_BEATS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PAYLOAD_BEATS - 1);

  abc_rx_state_e state_q;
  logic [CNT_W-1:0]                cnt_q;
  logic [DATA_W-1:0]               hdr_q;
  logic [PAYLOAD_BEATS*DATA_W-1:0] pay_q;
  logic                            valid_q;
  logic [DATA_W-1:0]               out_hdr_q;
  logic [PAYLOAD_BEATS*DATA_W-1:0] out_pay_q;
  logic [DATA_W-1:0]               out_trl_q;
  logic                            frame_err_q;
  logic                            ovf_err_q;

  // X or Z on the framing strobes never counts as asserted.
  logic sop_v, eop_v;
  assign sop_v = (sop === 1'b1);
  assign eop_v = (eop === 1'b1);

  logic trl_take, pkt_load;
  assign trl_take = (state_q == TRAILER) && eop_v && !sop_v;
  assign pkt_load = trl_take && (!valid_q || pkt_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hdr_q       <= '0;
      pay_q       <= '0;
      valid_q     <= 1'b0;
      out_hdr_q   <= '0;
      out_pay_q   <= '0;
      out_trl_q   <= '0;
      frame_err_q <= 1'b0;
      ovf_err_q   <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      ovf_err_q   <= 1'b0;
      if (valid_q && pkt_ready) begin
        valid_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (sop_v && !eop_v) begin
            hdr_q   <= data;
            cnt_q   <= '0;
            state_q <= PAYLOAD;
          end else if (eop_v) begin
            frame_err_q <= 1'b1;
          end
        end
        PAYLOAD: begin
          if (!sop_v && !eop_v) begin
            pay_q[int'(cnt_q)*DATA_W +: DATA_W] <= data;
            if (cnt_q == CNT_LAST) begin
              state_q <= TRAILER;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end else if (sop_v && !eop_v) begin
            hdr_q       <= data;
            cnt_q       <= '0;
            frame_err_q <= 1'b1;
          end else begin
            frame_err_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        TRAILER: begin
          if (trl_take) begin
            state_q <= IDLE;
            if (pkt_load) begin
              valid_q   <= 1'b1;
              out_hdr_q <= hdr_q;
              out_pay_q <= pay_q;
              out_trl_q <= data;
            end else begin
              ovf_err_q <= 1'b1;
            end
          end else if (sop_v && !eop_v) begin
            hdr_q       <= data;
            cnt_q       <= '0;
            frame_err_q <= 1'b1;
            state_q     <= PAYLOAD;
          end else begin
            frame_err_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ABC_RX_GAP_MEASURE_EN
  logic [GAP_W-1:0] hdr_gap;
  logic [GAP_W-1:0] out_gap_q;

  abc_rx_gap_counter #(.GAP_W(GAP_W)) u_gap (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (trl_take),
    .inc_i   ((state_q == IDLE) && !sop_v),
    .latch_i (sop_v && !eop_v),
    .gap_o   (hdr_gap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_gap_q <= '0;
    end else if (pkt_load) begin
      out_gap_q <= hdr_gap;
    end
  end

  assign pkt_gap = out_gap_q;
`else
  assign pkt_gap = '0;
`endif

  assign pkt_valid   = valid_q;
  assign pkt_header  = out_hdr_q;
  assign pkt_payload = out_pay_q;
  assign pkt_trailer = out_trl_q;
  assign frame_err   = frame_err_q;
  assign ovf_err     = ovf_err_q;

endmodule

// File: tb/tb_abc_rx.sv
// Bench for abc_rx: queue-based packet model with per-cycle compare plus literal checks.
module tb_abc_rx;

  localparam int DW = 64;
  localparam int PB = 8;
  localparam int GW = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic             sop, eop;
  logic [DW-1:0]    data;
  logic             pkt_valid, pkt_ready;
  logic [DW-1:0]    pkt_header, pkt_trailer;
  logic [PB*DW-1:0] pkt_payload;
  logic [GW-1:0]    pkt_gap;
  logic             frame_err, ovf_err;

  abc_rx dut (
    .clk(clk), .rst(rst), .sop(sop), .eop(eop), .data(data),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .pkt_header(pkt_header), .pkt_payload(pkt_payload),
    .pkt_trailer(pkt_trailer), .pkt_gap(pkt_gap),
    .frame_err(frame_err), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [PB*DW-1:0] got, input logic [PB*DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Model: beats of the frame being assembled; a frame is good only if it is
  // exactly header, PB plain beats, then an eop-only trailer.
  logic [DW-1:0]    frm[$];
  int               idle_cnt;
  logic [GW-1:0]    hdr_gap;
  logic             exp_valid, exp_ferr, exp_ovf;
  logic [DW-1:0]    exp_hdr, exp_trl;
  logic [PB*DW-1:0] exp_pay;
  logic [GW-1:0]    exp_gap;
  logic             m_s, m_e, m_done;

  function automatic logic [GW-1:0] gap_of(input int n);
    return (n + 1 > 63) ? 6'd63 : GW'(n + 1);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      frm.delete();
      idle_cnt  = 0;
      hdr_gap   = '0;
      exp_valid = 0; exp_ferr = 0; exp_ovf = 0;
      exp_hdr   = '0; exp_trl = '0; exp_pay = '0; exp_gap = '0;
    end else begin
      m_s = (sop === 1'b1);
      m_e = (eop === 1'b1);
      m_done = 0;
      exp_ferr = 0;
      exp_ovf  = 0;
      if (m_s && !m_e) begin
        if (frm.size() != 0) exp_ferr = 1;
        frm.delete();
        frm.push_back(data);
        hdr_gap = gap_of(idle_cnt);
      end else if (m_e) begin
        if (!m_s && frm.size() == PB + 1) begin
          m_done = 1;
          idle_cnt = 0;
        end else begin
          exp_ferr = 1;
          if (!m_s && frm.size() == 0 && idle_cnt < 63) idle_cnt++;
        end
        if (!m_done) frm.delete();
      end else begin
        if (frm.size() == 0) begin
          if (idle_cnt < 63) idle_cnt++;
        end else if (frm.size() == PB + 1) begin
          exp_ferr = 1;
          frm.delete();
        end else begin
          frm.push_back(data);
        end
      end
      if (m_done) begin
        if (!exp_valid || pkt_ready) begin
          exp_valid = 1;
          exp_hdr = frm[0];
          for (int k = 0; k < PB; k++) exp_pay[k*DW +: DW] = frm[k+1];
          exp_trl = data;
`ifdef ABC_RX_GAP_MEASURE_EN
          exp_gap = hdr_gap;
`else
          exp_gap = '0;
`endif
        end else begin
          exp_ovf = 1;
        end
        frm.delete();
      end else if (exp_valid && pkt_ready) begin
        exp_valid = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("valid", pkt_valid, exp_valid);
      chk("frame_err", frame_err, exp_ferr);
      chk("ovf_err", ovf_err, exp_ovf);
      if (exp_valid) begin
        chk("header", pkt_header, exp_hdr);
        chk("payload", pkt_payload, exp_pay);
        chk("trailer", pkt_trailer, exp_trl);
        chk("gap", pkt_gap, exp_gap);
      end
    end
  end

  // Log of accepted packets and error pulses, used by the literal checks.
  logic [DW-1:0]    hdr_log[$], trl_log[$];
  logic [PB*DW-1:0] pay_log[$];
  logic [GW-1:0]    gap_log[$];
  int ferr_n = 0, ovf_n = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (pkt_valid && pkt_ready) begin
        hdr_log.push_back(pkt_header);
        pay_log.push_back(pkt_payload);
        trl_log.push_back(pkt_trailer);
        gap_log.push_back(pkt_gap);
      end
      if (frame_err) ferr_n++;
      if (ovf_err) ovf_n++;
    end
  end

  task automatic beat(input logic s, input logic e, input logic [DW-1:0] d);
    @(posedge clk);
    #2;
    sop = s; eop = e; data = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(1'b0, 1'b0, 64'h0);
  endtask

  task automatic send_pkt(input logic [DW-1:0] h, input logic [DW-1:0] base, input logic [DW-1:0] t);
    beat(1'b1, 1'b0, h);
    for (int k = 0; k < PB; k++) beat(1'b0, 1'b0, base + 64'(k));
    beat(1'b0, 1'b1, t);
  endtask

  task automatic chk_pkt(input string nm, input int idx, input logic [DW-1:0] h,
                         input logic [DW-1:0] base, input logic [DW-1:0] t);
    logic [PB*DW-1:0] p;
    logic [DW-1:0] b;
    if (idx >= hdr_log.size()) begin
      chk({nm, "_present"}, 0, 1);
    end else begin
      chk({nm, "_hdr"}, hdr_log[idx], h);
      chk({nm, "_trl"}, trl_log[idx], t);
      p = pay_log[idx];
      for (int k = 0; k < PB; k++) begin
        b = p[k*DW +: DW];
        chk($sformatf("%s_pay%0d", nm, k), b, base + 64'(k));
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  int n0, f0, o0;
  logic [GW-1:0] g1, g4, g63;

  initial begin
    rst = 1'b1; sop = 0; eop = 0; data = '0; pkt_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", pkt_valid, 0);
    chk("rst_header", pkt_header, 0);
    chk("rst_payload", pkt_payload, 0);
    chk("rst_errs", {frame_err, ovf_err}, 0);
    @(posedge clk); #2; rst = 1'b0;
    idle(2);

    // 1: single clean packet
    n0 = hdr_log.size(); f0 = ferr_n; o0 = ovf_n;
    send_pkt(64'hA5, 64'h100, 64'h5A);
    idle(3);
    chk("t1_count", hdr_log.size() - n0, 1);
    chk_pkt("t1", n0, 64'hA5, 64'h100, 64'h5A);
    chk("t1_noerr", (ferr_n - f0) + (ovf_n - o0), 0);

    // 2: consumer stalled across two packets
    n0 = hdr_log.size(); o0 = ovf_n;
    pkt_ready = 1'b0;
    send_pkt(64'h11, 64'h200, 64'hE1);
    idle(3);
    send_pkt(64'h22, 64'h300, 64'hE2);
    beat(1'b0, 1'b0, 64'h0);
    pkt_ready = 1'b1;
    idle(3);
    chk("t2_ovf", ovf_n - o0, 1);
    chk("t2_count", hdr_log.size() - n0, 1);
    chk_pkt("t2", n0, 64'h11, 64'h200, 64'hE1);

    // 3: eop on payload beat 5
    n0 = hdr_log.size(); f0 = ferr_n;
    beat(1'b1, 1'b0, 64'h33);
    for (int k = 0; k < 5; k++) beat(1'b0, 1'b0, 64'h400 + 64'(k));
    beat(1'b0, 1'b1, 64'h405);
    idle(2);
    chk("t3_ferr", ferr_n - f0, 1);
    chk("t3_nopkt", hdr_log.size() - n0, 0);
    send_pkt(64'h34, 64'h500, 64'hE3);
    idle(3);
    chk_pkt("t3", n0, 64'h34, 64'h500, 64'hE3);

    // 4: sop on payload beat 3 restarts the frame
    n0 = hdr_log.size(); f0 = ferr_n;
    beat(1'b1, 1'b0, 64'h44);
    for (int k = 0; k < 3; k++) beat(1'b0, 1'b0, 64'h600 + 64'(k));
    send_pkt(64'hBEEF, 64'h700, 64'hE4);
    idle(3);
    chk("t4_ferr", ferr_n - f0, 1);
    chk("t4_count", hdr_log.size() - n0, 1);
    chk_pkt("t4", n0, 64'hBEEF, 64'h700, 64'hE4);

    // 5: reset in the middle of a packet while the last one is still shown
    pkt_ready = 1'b0;
    send_pkt(64'h50, 64'h800, 64'hE5);
    beat(1'b1, 1'b0, 64'h55);
    for (int k = 0; k < 4; k++) beat(1'b0, 1'b0, 64'h900 + 64'(k));
    @(posedge clk); #2; rst = 1'b1;
    #1;
    chk("t5_valid", pkt_valid, 0);
    chk("t5_header", pkt_header, 0);
    chk("t5_trailer", pkt_trailer, 0);
    chk("t5_payload", pkt_payload, 0);
    @(posedge clk); #2; rst = 1'b0; sop = 0; eop = 0; data = '0; pkt_ready = 1'b1;
    idle(2);
    n0 = hdr_log.size();
    send_pkt(64'h56, 64'hA00, 64'hE6);
    idle(3);
    chk("t5_count", hdr_log.size() - n0, 1);
    chk_pkt("t5", n0, 64'h56, 64'hA00, 64'hE6);

    // 6: back-to-back, then gaps of 3 and 70 idle beats
    n0 = hdr_log.size(); f0 = ferr_n;
    send_pkt(64'h61, 64'hB00, 64'hF1);
    send_pkt(64'h62, 64'hC00, 64'hF2);
    idle(3);
    send_pkt(64'h63, 64'hD00, 64'hF3);
    idle(70);
    send_pkt(64'h64, 64'hE00, 64'hF4);
    idle(3);
    chk("t6_count", hdr_log.size() - n0, 4);
    chk("t6_noerr", ferr_n - f0, 0);
    chk_pkt("t6a", n0, 64'h61, 64'hB00, 64'hF1);
    chk_pkt("t6b", n0 + 1, 64'h62, 64'hC00, 64'hF2);
`ifdef ABC_RX_GAP_MEASURE_EN
    g1 = 6'd1; g4 = 6'd4; g63 = 6'd63;
`else
    g1 = 6'd0; g4 = 6'd0; g63 = 6'd0;
`endif
    if (hdr_log.size() >= n0 + 4) begin
      chk("t6_gap_b2b", gap_log[n0+1], g1);
      chk("t6_gap_3", gap_log[n0+2], g4);
      chk("t6_gap_sat", gap_log[n0+3], g63);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
